// File: rtl/three_bit_dff_down_counter_pkg.sv
// three_bit_dff_down_counter_pkg: shared width, reload reset value and count reset value
package three_bit_dff_down_counter_pkg;
  localparam int CNT_WIDTH = 3;
  localparam logic [63:0] CNT_RELOAD_RST = '1;
  localparam logic [63:0] CNT_RST_VAL = '0;
endpackage

// File: rtl/dff_sync_clr.sv
// dff_sync_clr: D flop with synchronous active-high clear (clk, clr, d in; q out)
module dff_sync_clr #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) q <= clr ? RST_VAL : d;
endmodule

// File: rtl/three_bit_dff_down_counter.sv
// three_bit_dff_down_counter: loadable down counter with wrap/auto-reload (Clk, Clr, En, Load, LoadVal, AutoReload in; count, Borrow, Zero out)
module three_bit_dff_down_counter
  import three_bit_dff_down_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter logic [WIDTH-1:0] RELOAD_RST = WIDTH'(CNT_RELOAD_RST)
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             AutoReload,
  output logic [WIDTH-1:0] count,
  output logic             Borrow,
  output logic             Zero
);
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(CNT_RST_VAL);
  logic [WIDTH-1:0] count_d, reload_d, reload_q;
  logic borrow_d, borrow_q, underflow;
  always_comb begin
    underflow = En && !Load && count == '0;
    count_d = Load ? LoadVal : !En ? count : underflow ? (AutoReload ? reload_q : '1) : count - 1'b1;
    reload_d = Load ? LoadVal : reload_q;
    borrow_d = underflow;
  end
  always_ff @(posedge Clk) begin
    reload_q <= Clr ? RELOAD_RST : reload_d;
    borrow_q <= Clr ? 1'b0 : borrow_d;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_sync_clr #(.RST_VAL(CNT_RST[i])) u_dff (
      .clk(Clk),
      .clr(Clr),
      .d  (count_d[i]),
      .q  (count[i])
    );
  end
  assign Borrow = borrow_q;
  assign Zero = count == '0;
endmodule

// File: tb/tb_three_bit_dff_down_counter.sv
// tb_three_bit_dff_down_counter: directed stimulus with literal expectations plus a per-cycle behavioural model check
module tb_three_bit_dff_down_counter;
  logic Clk = 0, Clr = 0, En = 0, Load = 0, AutoReload = 0;
  logic [2:0] LoadVal = '0;
  logic [2:0] count;
  logic Borrow, Zero;
  int checks = 0, passes = 0;
  int m_count = 0, m_reload = 7;
  bit m_borrow = 0, m_valid = 0;

  three_bit_dff_down_counter dut (
    .Clk(Clk), .Clr(Clr), .En(En), .Load(Load), .LoadVal(LoadVal),
    .AutoReload(AutoReload), .count(count), .Borrow(Borrow), .Zero(Zero)
  );

  always #20 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Clr) begin
      m_count = 0; m_reload = 7; m_borrow = 0; m_valid = 1;
    end else if (Load) begin
      m_count = int'(LoadVal); m_reload = int'(LoadVal); m_borrow = 0;
    end else if (En && m_count == 0) begin
      m_count = AutoReload ? m_reload : 7; m_borrow = 1;
    end else if (En) begin
      m_count = m_count - 1; m_borrow = 0;
    end else
      m_borrow = 0;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
  endtask

  always @(negedge Clk) if (m_valid) begin
    chk("model_count", int'(count), m_count);
    chk("model_borrow", int'(Borrow), int'(m_borrow));
    chk("model_zero", int'(Zero), int'(m_count == 0));
  end

  task automatic cyc(input bit c, input bit l, input bit e, input int lv, input bit ar);
    Clr = c; Load = l; En = e; LoadVal = 3'(lv); AutoReload = ar;
    @(negedge Clk);
  endtask

  task automatic exp(input string name, input int c, input bit b);
    chk({name, "_count"}, int'(count), c);
    chk({name, "_borrow"}, int'(Borrow), int'(b));
    chk({name, "_zero"}, int'(Zero), int'(c == 0));
  endtask

  initial begin
    int seq29[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int seq30[6] = '{4, 3, 2, 1, 0, 5};
    @(negedge Clk);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    exp("reset", 0, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 1, 0, 0);
      exp("wrap", seq29[i], i == 0 || i == 8);
    end
    cyc(0, 1, 0, 5, 1);
    exp("load5", 5, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0, 1);
      exp("autoreload", seq30[i], i == 5);
    end
    cyc(0, 1, 1, 3, 1);
    exp("load_en", 3, 0);
    cyc(0, 1, 0, 4, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, i[0]);
      exp("hold", 4, 0);
    end
    cyc(0, 1, 0, 2, 1);
    exp("load2", 2, 0);
    cyc(1, 1, 1, 5, 1);
    exp("clr_prio", 0, 0);
    cyc(0, 0, 1, 0, 1);
    exp("reload_rst", 7, 1);
    cyc(0, 1, 0, 1, 1);
    cyc(0, 0, 1, 0, 0);
    exp("ar_ignored", 0, 0);
    cyc(0, 0, 1, 0, 1);
    exp("ar_sampled", 1, 1);
    cyc(0, 1, 0, 0, 1);
    exp("load0", 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 1);
      exp("stuck0", 0, 1);
    end
    cyc(0, 0, 0, 0, 1);
    exp("pulse_end", 0, 0);
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
